rice_core_retire_monitor: RTL and testbench

Passive consumer of the core pipeline interface through its `monitor` modport. Detects instruction retirement at the EX stage, packs each retirement into a trace record, buffers records in a small FIFO, and delivers them on a valid/ready stream. Also maintains performance counters for retired instructions, stall cycles, flushes and dropped records. Sits beside the core in simulation and debug builds; it never drives any pipeline signal.

---
 rtl/rice_core_pkg.sv | 35 +++
 rtl/rice_core_pipeline_if.sv | 15 +
 rtl/rice_core_trace_fifo.sv | 51 +++++
 rtl/rice_core_retire_monitor.sv | 137 +++++++++++++
 tb/tb_rice_core_retire_monitor.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rice_core_pkg.sv
// Shared core definitions: result and trace record types plus sizing helpers.
// The type macro is expanded inside each XLEN-parameterised unit so that
// struct widths follow the local XLEN rather than a package-wide constant.

// Expands to the pipeline result and trace record struct typedefs for a given XLEN.
`define RICE_CORE_DEFINE_TYPES(XLEN) \
  typedef struct packed { \
    logic              valid; \
    logic [XLEN-1:0]   pc; \
    logic [31:0]       inst; \
    logic [4:0]        rd; \
    logic              rd_write; \
    logic [XLEN-1:0]   rd_value; \
  } rice_core_ex_result; \
  typedef struct packed { \
    logic [31:0]       seq; \
    logic [XLEN-1:0]   pc; \
    logic [31:0]       inst; \
    logic [4:0]        rd; \
    logic              rd_write; \
    logic [XLEN-1:0]   rd_value; \
    logic              gap; \
  } rice_core_trace_entry;

package rice_core_pkg;

  localparam int SEQ_WIDTH = 32;

  // Flat width of rice_core_trace_entry, for ports that must be sized before
  // the struct typedef is in scope: seq + pc + inst + rd + rd_write + rd_value + gap.
  function automatic int trace_entry_bits(input int xlen);
    return SEQ_WIDTH + xlen + 32 + 5 + 1 + xlen + 1;
  endfunction

endpackage

// File: rtl/rice_core_pipeline_if.sv
// Core pipeline interface: EX-stage result plus stall/flush qualifiers.
// core modport drives everything; monitor modport only observes.
// No flow control of its own; stall is the pipeline's backpressure.
interface rice_core_pipeline_if #(
  parameter int XLEN = 32
);
  `RICE_CORE_DEFINE_TYPES(XLEN)

  rice_core_ex_result ex_result;
  logic               stall;
  logic               flush;

  modport core    (output ex_result, output stall, output flush);
  modport monitor (input  ex_result, input  stall, input  flush);
endinterface

// File: rtl/rice_core_trace_fifo.sv
// Synchronous FIFO for trace records; pointers carry an extra wrap bit for full/empty.
// Latency: entry written at edge N is visible on head after edge N (no bypass).
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk/rst (sync, active-high), push/push_entry, pop, full, empty, head.
module rice_core_trace_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  // Same slot index but opposite lap: writer is one full lap ahead.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO is still safe.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // Masking when empty keeps the head at zero out of reset and between bursts.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/rice_core_retire_monitor.sv
// Passive retire monitor: packs each EX-stage retirement into a trace record and streams it out.
// Latency: record for a retire sampled at edge N is presented after edge N; counters update at edge N.
// Backpressure: valid/ready output; on FIFO overflow records are dropped until drained, then gap=1.
// Ports: i_clk/i_rst (sync, active-high), pipeline_if (monitor modport), i_enable,
//        o_trace_valid/i_trace_ready/o_trace stream, performance counters o_*.
module rice_core_retire_monitor
  import rice_core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  rice_core_pipeline_if.monitor              pipeline_if,
  input  logic                               i_enable,
  output logic                               o_trace_valid,
  input  logic                               i_trace_ready,
  output logic [trace_entry_bits(XLEN)-1:0]  o_trace,
  output logic [CNT_WIDTH-1:0]               o_instret,
  output logic [CNT_WIDTH-1:0]               o_stall_cycles,
  output logic [CNT_WIDTH-1:0]               o_flush_count,
  output logic [CNT_WIDTH-1:0]               o_drop_count
);
  `RICE_CORE_DEFINE_TYPES(XLEN)

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DROP   = 2'd1,
    RESYNC = 2'd2
  } mon_state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};

  mon_state_e           state_q;
  mon_state_e           state_d;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic                 retire;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 gap;
  logic                 fifo_full;
  logic                 fifo_empty;
  rice_core_trace_entry push_entry;
  rice_core_trace_entry head_entry;

  // A flushing branch/jump still retires: flush does not qualify the event.
  assign retire = pipeline_if.ex_result.valid && !pipeline_if.stall && i_enable;
  assign pop    = o_trace_valid && i_trace_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    gap     = 1'b0;
    // With capture disabled the FSM holds; the FIFO keeps draining independently.
    if (i_enable) begin
      case (state_q)
        RUN: begin
          if (retire) begin
            if (!fifo_full || pop) begin
              push = 1'b1;
            end else begin
              drop    = 1'b1;
              state_d = DROP;
            end
          end
        end
        DROP: begin
          // Stay lossy until the consumer has caught up completely, so the
          // next kept record marks a clean discontinuity.
          if (retire)     drop    = 1'b1;
          if (fifo_empty) state_d = RESYNC;
        end
        RESYNC: begin
          if (retire) begin
            push    = 1'b1;
            gap     = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    push_entry          = '0;
    push_entry.seq      = seq_q;
    push_entry.pc       = pipeline_if.ex_result.pc;
    push_entry.inst     = pipeline_if.ex_result.inst;
    push_entry.rd       = pipeline_if.ex_result.rd;
    push_entry.rd_write = pipeline_if.ex_result.rd_write;
    push_entry.rd_value = pipeline_if.ex_result.rd_value;
    push_entry.gap      = gap;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= RUN;
      seq_q          <= '0;
      o_instret      <= '0;
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
      o_drop_count   <= '0;
    end else begin
      state_q <= state_d;
      // seq advances on every retire, kept or dropped, so gaps are visible downstream.
      if (retire) begin
        seq_q     <= seq_q + SEQ_ONE;
        o_instret <= o_instret + CNT_ONE;
      end
      if (i_enable && pipeline_if.stall) o_stall_cycles <= o_stall_cycles + CNT_ONE;
      if (i_enable && pipeline_if.flush) o_flush_count  <= o_flush_count + CNT_ONE;
      if (drop)                          o_drop_count   <= o_drop_count + CNT_ONE;
    end
  end

  rice_core_trace_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rice_core_trace_entry)
  ) u_trace_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head_entry)
  );

  assign o_trace_valid = !fifo_empty;
  assign o_trace       = head_entry;
endmodule

// File: tb/tb_rice_core_retire_monitor.sv
// Directed bench for the retire monitor with a queue scoreboard of expected trace records.
module tb_rice_core_retire_monitor;
  `RICE_CORE_DEFINE_TYPES(32)

  localparam int DEPTH = 4;

  typedef enum int {M_RUN, M_DROP, M_RESYNC} m_state_e;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 trace_valid;
  logic                 trace_ready;
  rice_core_trace_entry trace;
  logic [63:0]          instret;
  logic [63:0]          stall_cycles;
  logic [63:0]          flush_count;
  logic [63:0]          drop_count;

  int checks = 0;
  int errors = 0;

  rice_core_trace_entry q[$];
  bit [63:0] m_instret, m_stall, m_flush, m_drop;
  bit [31:0] m_seq;
  m_state_e  m_state;
  bit        check_zero;

  rice_core_pipeline_if #(.XLEN(32)) pif ();

  rice_core_retire_monitor #(
    .XLEN       (32),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (64)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .pipeline_if    (pif),
    .i_enable       (enable),
    .o_trace_valid  (trace_valid),
    .i_trace_ready  (trace_ready),
    .o_trace        (trace),
    .o_instret      (instret),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count),
    .o_drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_trace(input string tag, input rice_core_trace_entry obs,
                           input rice_core_trace_entry exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed seq=%0d pc=%0h gap=%0b (0x%0h) expected seq=%0d pc=%0h gap=%0b (0x%0h)",
             tag, obs.seq, obs.pc, obs.gap, obs, exp.seq, exp.pc, exp.gap, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against the
  // model, advance the model across the next rising edge, return just after it.
  task automatic step(input bit v, input bit st, input bit fl, input bit rdy,
                      input bit en, input bit r);
    rice_core_trace_entry rec;
    int                   occ;
    bit                   popping;
    bit                   ret;
    m_state_e             prev;
    @(negedge clk);
    pif.ex_result.valid    = v;
    pif.ex_result.pc       = $urandom;
    pif.ex_result.inst     = $urandom;
    pif.ex_result.rd       = 5'($urandom_range(0, 31));
    pif.ex_result.rd_write = 1'($urandom_range(0, 1));
    pif.ex_result.rd_value = $urandom;
    pif.stall              = st;
    pif.flush              = fl;
    trace_ready            = rdy;
    enable                 = en;
    rst                    = r;

    occ = q.size();
    chk("trace_valid", {63'd0, trace_valid}, {63'd0, occ != 0});
    if (occ != 0)       chk_trace("trace_head", trace, q[0]);
    else if (check_zero) chk_trace("trace_reset_zero", trace, '0);
    check_zero = 1'b0;
    chk("instret", instret, m_instret);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    chk("drop_count", drop_count, m_drop);

    if (r) begin
      q.delete();
      m_instret  = '0;
      m_stall    = '0;
      m_flush    = '0;
      m_drop     = '0;
      m_seq      = '0;
      m_state    = M_RUN;
      check_zero = 1'b1;
    end else begin
      popping = (occ != 0) && rdy;
      if (popping) void'(q.pop_front());
      ret  = v && !st && en;
      prev = m_state;
      if (en) begin
        if (st) m_stall++;
        if (fl) m_flush++;
        if (ret) begin
          m_instret++;
          rec          = '0;
          rec.seq      = m_seq;
          rec.pc       = pif.ex_result.pc;
          rec.inst     = pif.ex_result.inst;
          rec.rd       = pif.ex_result.rd;
          rec.rd_write = pif.ex_result.rd_write;
          rec.rd_value = pif.ex_result.rd_value;
          case (m_state)
            M_RUN: begin
              if (occ < DEPTH || popping) q.push_back(rec);
              else begin
                m_drop++;
                m_state = M_DROP;
              end
            end
            M_DROP: m_drop++;
            default: begin
              rec.gap = 1'b1;
              q.push_back(rec);
              m_state = M_RUN;
            end
          endcase
          m_seq++;
        end
        if (prev == M_DROP && occ == 0) m_state = M_RESYNC;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit bv;
    bit br;
    rst                    = 1'b1;
    enable                 = 1'b1;
    trace_ready            = 1'b0;
    pif.ex_result          = '0;
    pif.stall              = 1'b0;
    pif.flush              = 1'b0;
    m_instret = '0; m_stall = '0; m_flush = '0; m_drop = '0; m_seq = '0;
    m_state    = M_RUN;
    check_zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values.
    step(0, 0, 0, 0, 1, 0);

    // Basic retire: three back-to-back events, consumer always ready.
    repeat (3) step(1, 0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 1, 1, 0);
    chk("basic_instret", instret, 64'd3);

    // Stall for four cycles, then a flushing branch retires.
    repeat (4) step(1, 1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    repeat (2) step(0, 0, 0, 1, 1, 0);
    chk("stall_count", stall_cycles, 64'd4);
    chk("flush_count_one", flush_count, 64'd1);
    chk("instret_after_flush", instret, 64'd4);

    // Capture disabled: nothing counted or captured.
    repeat (3) step(1, 1, 1, 1, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0);
    chk("disabled_instret", instret, 64'd4);
    chk("disabled_stall", stall_cycles, 64'd4);

    // Fresh start, then overflow with consumer stalled.
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    repeat (6) step(1, 0, 0, 0, 1, 0);
    chk("overflow_drop", drop_count, 64'd2);
    chk("overflow_valid", {63'd0, trace_valid}, 64'd1);
    // Drain, then the next kept record carries seq 6 with gap set.
    repeat (5) step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 1, 1, 0);

    // Full FIFO with simultaneous pop and retire is not an overflow.
    repeat (4) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    chk("full_pop_drop", drop_count, 64'd2);
    repeat (6) step(0, 0, 0, 1, 1, 0);

    // Random backpressure over 20 retire events.
    n = 0;
    for (int i = 0; i < 400 && n < 20; i++) begin
      bv = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 3) != 0);
      step(bv, 0, 0, br, 1, 0);
      if (bv) n++;
    end
    chk("bp_retire_events", 64'(n), 64'd20);
    repeat (8) step(0, 0, 0, 1, 1, 0);

    // Reset with two records buffered.
    repeat (2) step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("rst_valid", {63'd0, trace_valid}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_drop", drop_count, 64'd0);
    step(1, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
